// File: rtl/game_director.sv
// Frame-synchronous game sequencer: TITLE/PLAY/OVER control, per-frame camera scroll
// requests, saturating score/camera, high score and difficulty latched at game start.
module game_director #(
    parameter int SCREEN_H        = 600,
    parameter int DEATH_MARGIN    = 8,
    parameter int SCROLL_LINE     = 200,
    parameter int SCROLL_MAX_STEP = 8,
    parameter int CAM_W           = 16,
    parameter int SCORE_W         = 20,
    parameter int OVER_FRAMES     = 120
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_tick_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [9:0]         doodle_y_i,
    input  logic               doodle_falling_i,
    output logic [1:0]         state_o,
    output logic               play_en_o,
    output logic               doodle_rst_o,
    output logic               scroll_valid_o,
    output logic [3:0]         scroll_dy_o,
    output logic [CAM_W-1:0]   camera_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] high_score_o,
    output logic               game_over_o
);

    typedef enum logic [1:0] {
        S_TITLE = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2
    } state_e;

    localparam int              OCW      = $clog2(OVER_FRAMES + 1);
    localparam logic [10:0]     DEATH_Y  = 11'(SCREEN_H - DEATH_MARGIN);
    localparam logic [10:0]     SCROLL_Y = 11'(SCROLL_LINE);
    localparam logic [10:0]     MAX_STEP = 11'(SCROLL_MAX_STEP);
    localparam logic [3:0]      MAX_DY   = 4'(SCROLL_MAX_STEP);
    localparam logic [OCW-1:0]  OVER_MAX = OCW'(OVER_FRAMES);

    state_e             state_q;
    logic               start_q;
    logic [1:0]         mode_q;
    logic [OCW-1:0]     over_cnt_q;
    logic               scroll_valid_q;
    logic [3:0]         scroll_dy_q;
    logic [CAM_W-1:0]   camera_q, camera_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_score_q;

    logic [10:0]        y_ext, diff;
    logic               died, want_scroll, start_edge, can_start;
    logic [3:0]         dy;
    logic [2:0]         mult_f;
    logic [6:0]         gain;
    logic [SCORE_W:0]   score_sum;
    logic [CAM_W:0]     cam_sum;

    // y is widened so values at or beyond SCREEN_H compare as fallen instead of wrapping
    assign y_ext       = {1'b0, doodle_y_i};
    assign died        = doodle_falling_i && (y_ext >= DEATH_Y);
    assign want_scroll = y_ext < SCROLL_Y;
    assign diff        = SCROLL_Y - y_ext;
    assign dy          = (diff > MAX_STEP) ? MAX_DY : diff[3:0];

    assign mult_f    = {1'b0, mode_q} + 3'd1;
    assign gain      = {3'b000, dy} * {4'b0000, mult_f};
    assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(gain);
    assign cam_sum   = {1'b0, camera_q} + (CAM_W+1)'(dy);
    assign score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign camera_d  = cam_sum[CAM_W] ? '1 : cam_sum[CAM_W-1:0];

    assign start_edge = start_i & ~start_q;
    assign can_start  = start_edge &&
                        ((state_q == S_TITLE) || (state_q == S_OVER && over_cnt_q == OVER_MAX));

    // The re-init pulse coincides with the accepted start edge so world blocks restart
    // in the same cycle the mode is latched; it is masked while reset is asserted.
    assign doodle_rst_o = can_start && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_TITLE;
            start_q        <= 1'b0;
            mode_q         <= 2'd0;
            over_cnt_q     <= '0;
            scroll_valid_q <= 1'b0;
            scroll_dy_q    <= 4'd0;
            camera_q       <= '0;
            score_q        <= '0;
            high_score_q   <= '0;
        end else begin
            start_q        <= start_i;
            scroll_valid_q <= 1'b0;
            scroll_dy_q    <= 4'd0;
            case (state_q)
                S_TITLE: begin
                    if (can_start) begin
                        state_q  <= S_PLAY;
                        mode_q   <= mode_i;
                        camera_q <= '0;
                        score_q  <= '0;
                    end
                end
                S_PLAY: begin
                    if (frame_tick_i) begin
                        if (died) begin
                            state_q    <= S_OVER;
                            over_cnt_q <= '0;
                            if (score_q > high_score_q)
                                high_score_q <= score_q;
                        end else if (want_scroll) begin
                            scroll_valid_q <= 1'b1;
                            scroll_dy_q    <= dy;
                            camera_q       <= camera_d;
                            score_q        <= score_d;
                        end
                    end
                end
                S_OVER: begin
                    if (can_start) begin
                        state_q  <= S_PLAY;
                        mode_q   <= mode_i;
                        camera_q <= '0;
                        score_q  <= '0;
                    end else if (frame_tick_i && over_cnt_q != OVER_MAX) begin
                        over_cnt_q <= over_cnt_q + OCW'(1);
                    end
                end
                default: state_q <= S_TITLE;
            endcase
        end
    end

    assign state_o        = state_q;
    assign play_en_o      = (state_q == S_PLAY);
    assign game_over_o    = (state_q == S_OVER);
    assign scroll_valid_o = scroll_valid_q;
    assign scroll_dy_o    = scroll_dy_q;
    assign camera_o       = camera_q;
    assign score_o        = score_q;
    assign high_score_o   = high_score_q;

endmodule

// File: tb/tb_game_director.sv
// Bench for game_director: table of per-cycle vectors, hand sequences for OVER hold-off,
// saturation and reset, and a scroll scoreboard checked whenever scroll_valid fires.
module tb_game_director;

    logic        clk = 1'b0;
    logic        rst, tick, start, fall;
    logic [1:0]  mode;
    logic [9:0]  y;
    logic [1:0]  state;
    logic        play_en, drst, sv, game_over;
    logic [3:0]  sdy;
    logic [15:0] camera;
    logic [19:0] score, high;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    game_director dut (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(tick), .start_i(start), .mode_i(mode),
        .doodle_y_i(y), .doodle_falling_i(fall), .state_o(state), .play_en_o(play_en),
        .doodle_rst_o(drst), .scroll_valid_o(sv), .scroll_dy_o(sdy), .camera_o(camera),
        .score_o(score), .high_score_o(high), .game_over_o(game_over)
    );

    typedef struct {
        logic r, t, s; logic [1:0] m; logic [9:0] y; logic f;
        logic ep; logic [1:0] est; logic esv; logic [3:0] edy;
        logic [19:0] esc, ehi; logic [15:0] ecam;
    } vec_t;

    typedef struct { logic [3:0] dy; logic [19:0] sc; logic [15:0] cam; } sb_t;

    sb_t sbq[$];
    sb_t e_mon;
    logic mon_en = 1'b0;
    int m_score, m_cam;
    int m_mode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, t, s, input logic [1:0] m, input logic [9:0] yy,
                         input logic f);
        rst = r; tick = t; start = s; mode = m; y = yy; fall = f;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_scroll(input logic [9:0] yy);
        int d;
        d = 200 - int'(yy);
        if (d > 8) d = 8;
        m_score = m_score + d * (m_mode + 1);
        if (m_score > 1048575) m_score = 1048575;
        m_cam = m_cam + d;
        if (m_cam > 65535) m_cam = 65535;
        sbq.push_back('{4'(d), 20'(m_score), 16'(m_cam)});
        drive(0, 1, 0, 0, yy, 0);
        cycle();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sv) begin
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_unexpected: scroll_valid with dy %0d, none expected", sdy);
                end else begin
                    e_mon = sbq.pop_front();
                    chk("sb_scroll", {sdy, score, camera}, {e_mon.dy, e_mon.sc, e_mon.cam});
                end
            end else begin
                chk("dy_idle", 64'(sdy), 64'd0);
            end
            chk("pulse_excl", 64'(drst & sv), 64'd0);
        end
    end

    vec_t vecs[10];

    initial begin
        //          r  t  s  m  y    f   ep st sv dy score hi cam
        vecs[0] = '{1, 0, 0, 0, 300, 0,  0, 0, 0, 0, 0,  0, 0};
        vecs[1] = '{0, 0, 0, 0, 300, 0,  0, 0, 0, 0, 0,  0, 0};
        vecs[2] = '{0, 1, 1, 0, 100, 0,  1, 1, 0, 0, 0,  0, 0};
        vecs[3] = '{0, 0, 1, 0, 300, 0,  0, 1, 0, 0, 0,  0, 0};
        vecs[4] = '{0, 1, 1, 0, 196, 0,  0, 1, 1, 4, 4,  0, 4};
        vecs[5] = '{0, 0, 0, 0, 196, 0,  0, 1, 0, 0, 4,  0, 4};
        vecs[6] = '{0, 1, 0, 3, 100, 0,  0, 1, 1, 8, 12, 0, 12};
        vecs[7] = '{0, 1, 1, 0, 591, 1,  0, 1, 0, 0, 12, 0, 12};
        vecs[8] = '{0, 1, 0, 0, 592, 1,  0, 2, 0, 0, 12, 12, 12};
        vecs[9] = '{0, 0, 1, 0, 300, 0,  0, 2, 0, 0, 12, 12, 12};

        drive(1, 0, 0, 0, 300, 0);
        cycle();
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].m, vecs[i].y, vecs[i].f);
            @(negedge clk);
            chk($sformatf("row%0d_pulse", i), 64'(drst), 64'(vecs[i].ep));
            if (vecs[i].esv)
                sbq.push_back('{vecs[i].edy, vecs[i].esc, vecs[i].ecam});
            cycle();
            chk($sformatf("row%0d_out", i), {state, sv, sdy, score, high, camera},
                {vecs[i].est, vecs[i].esv, vecs[i].edy, vecs[i].esc, vecs[i].ehi, vecs[i].ecam});
        end
        chk("game_over_flag", 64'(game_over), 64'd1);
        chk("play_en_over", 64'(play_en), 64'd0);

        // OVER hold-off: restart refused before 120 frames, accepted at exactly 120
        drive(0, 0, 0, 0, 300, 0); cycle();
        for (int i = 0; i < 50; i++) begin drive(0, 1, 0, 0, 300, 0); cycle(); end
        drive(0, 0, 1, 0, 300, 0);
        @(negedge clk); chk("over50_pulse", 64'(drst), 64'd0);
        cycle(); chk("over50_state", 64'(state), 64'd2);
        drive(0, 0, 0, 0, 300, 0); cycle();
        for (int i = 0; i < 69; i++) begin drive(0, 1, 0, 0, 300, 0); cycle(); end
        drive(0, 0, 1, 0, 300, 0);
        @(negedge clk); chk("over119_pulse", 64'(drst), 64'd0);
        cycle(); chk("over119_state", 64'(state), 64'd2);
        drive(0, 1, 0, 0, 300, 0); cycle();
        drive(0, 0, 1, 3, 300, 0);
        @(negedge clk); chk("over120_pulse", 64'(drst), 64'd1);
        cycle();
        chk("restart_out", {state, score, high, camera}, {2'd1, 20'd0, 20'd12, 16'd0});
        chk("play_en_play", 64'(play_en), 64'd1);

        // mode 3 scoring, clamp to 8, minimum step 1, then drive into saturation
        m_mode = 3; m_score = 0; m_cam = 0;
        do_scroll(10'd100);
        chk("mode3_score", 64'(score), 64'd32);
        do_scroll(10'd199);
        chk("step1_score", {score, camera}, {20'd36, 16'd9});
        for (int i = 0; i < 32800; i++) do_scroll(10'd100);
        drive(0, 0, 0, 0, 300, 0); cycle(); cycle();
        chk("score_sat", 64'(score), 64'd1048575);
        chk("camera_sat", 64'(camera), 64'd65535);

        // y beyond the screen counts as fallen
        drive(0, 1, 0, 0, 1000, 1); cycle();
        drive(0, 0, 0, 0, 300, 0); cycle();
        chk("offscreen_death", {state, high}, {2'd2, 20'd1048575});

        drive(1, 0, 0, 0, 300, 0); cycle();
        drive(0, 0, 0, 0, 300, 0);
        chk("rst_midgame", {state, score, high, camera, play_en, game_over, sv},
            {2'd0, 20'd0, 20'd0, 16'd0, 1'b0, 1'b0, 1'b0});
        cycle();
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
